// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp.
// Groups the decode-stage read ports, writeback ports, issue/scoreboard
// controls and the stall qualifier. clk/reset stay outside as plain ports.
//   master : drives stall, read indices, write ports and issue; observes read results
//   slave  : the register file itself
interface regfile_mp_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 2
);
   logic                       stall;
   logic [NUM_RD*ADDR_W-1:0]   rs_addr;
   logic [NUM_RD*DATA_W-1:0]   rs_data;
   logic [NUM_RD-1:0]          rs_busy;
   logic [NUM_WR-1:0]          wr_en;
   logic [NUM_WR*ADDR_W-1:0]   wr_addr;
   logic [NUM_WR*DATA_W-1:0]   wr_data;
   logic                       issue_en;
   logic [ADDR_W-1:0]          issue_rd;

   modport master (
      output stall, rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
      input  rs_data, rs_busy
   );

   modport slave (
      input  stall, rs_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
      output rs_data, rs_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional write-to-read bypass
// and a per-register busy scoreboard for read-after-write hazard detection.
// Ports:
//   clk    : clock, all state updates on rising edge
//   reset  : synchronous active-high reset (clears registers and busy bits)
//   bus    : regfile_mp_if.slave
//            stall            freeze writes/issue/busy clears, reads stay live
//            rs_addr/rs_data  NUM_RD combinational read ports
//            rs_busy          pending, un-bypassed producer on read port i
//            wr_en/addr/data  NUM_WR write ports, higher index has priority
//            issue_en/rd      marks issue_rd busy on the next edge
module regfile_mp #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input logic         clk,
   input logic         reset,
   regfile_mp_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0]        regs [DEPTH];
   logic [DEPTH-1:0]         busy;
   logic [DEPTH-1:0]         busy_nxt;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;

   // Next busy vector: clears from writebacks first, issue set applied last so it wins
   always_comb begin
      logic [ADDR_W-1:0] wa;
      busy_nxt = busy;
      wa       = '0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         wa = bus.wr_addr[j*ADDR_W +: ADDR_W];
         if (bus.wr_en[j]) begin
            busy_nxt[wa] = 1'b0;
         end
      end
      if (bus.issue_en && !(ZERO_REG && bus.issue_rd == '0)) begin
         busy_nxt[bus.issue_rd] = 1'b1;
      end
      if (ZERO_REG) begin
         busy_nxt[0] = 1'b0;
      end
   end

   // Register array and scoreboard; ascending port loop makes the highest write port win
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
         busy <= '0;
      end else if (!bus.stall) begin
         for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] &&
                !(ZERO_REG && bus.wr_addr[j*ADDR_W +: ADDR_W] == '0)) begin
               regs[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
            end
         end
         busy <= busy_nxt;
      end
   end

   // Read ports with same-cycle forwarding; a forwarding hit also hides the busy bit
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      logic              rb;
      logic              hit;
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      rd      = '0;
      rb      = 1'b0;
      hit     = 1'b0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         ra  = bus.rs_addr[i*ADDR_W +: ADDR_W];
         rd  = regs[ra];
         rb  = busy[ra];
         hit = 1'b0;
         if (BYPASS && !bus.stall && !(ZERO_REG && ra == '0)) begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
               if (bus.wr_en[j] && bus.wr_addr[j*ADDR_W +: ADDR_W] == ra) begin
                  rd  = bus.wr_data[j*DATA_W +: DATA_W];
                  hit = 1'b1;
               end
            end
         end
         if (ZERO_REG && ra == '0) begin
            rd = '0;
            rb = 1'b0;
         end
         if (hit) begin
            rb = 1'b0;
         end
         rd_data[i*DATA_W +: DATA_W] = rd;
         rd_busy[i]                  = rb;
      end
   end

   assign bus.rs_data = rd_data;
   assign bus.rs_busy = rd_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (default parameters: 32x32, 2R/2W, ZERO_REG, BYPASS).
module tb_regfile_mp;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus_if ();

   regfile_mp #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
      .ZERO_REG(1'b1), .BYPASS(1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_if.stall    = 1'b0;
      bus_if.wr_en    = '0;
      bus_if.wr_addr  = '0;
      bus_if.wr_data  = '0;
      bus_if.issue_en = 1'b0;
      bus_if.issue_rd = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      idle();
      bus_if.rs_addr = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;

      // reset state on every index, both ports
      for (int a = 0; a < 32; a++) begin
         bus_if.rs_addr = {5'(a), 5'(a)};
         #1;
         check($sformatf("rst_d0_r%0d", a), bus_if.rs_data[31:0], 32'h0);
         check($sformatf("rst_d1_r%0d", a), bus_if.rs_data[63:32], 32'h0);
         check($sformatf("rst_b_r%0d", a), 32'(bus_if.rs_busy), 32'h0);
      end

      // two ports writing reg5: port 1 wins (also seen via bypass)
      bus_if.wr_en   = 2'b11;
      bus_if.wr_addr = {5'd5, 5'd5};
      bus_if.wr_data = {32'h12345678, 32'hDEADBEEF};
      bus_if.rs_addr = {5'd0, 5'd5};
      #1;
      check("wprio_bypass", bus_if.rs_data[31:0], 32'h12345678);
      tick();
      idle();
      bus_if.rs_addr = {5'd5, 5'd5};
      #1;
      check("wprio_p0", bus_if.rs_data[31:0], 32'h12345678);
      check("wprio_p1", bus_if.rs_data[63:32], 32'h12345678);

      // reg7 = 1, then bypass hit, then same write under stall
      bus_if.wr_en   = 2'b01;
      bus_if.wr_addr = {5'd0, 5'd7};
      bus_if.wr_data = {32'h0, 32'h1};
      tick();
      bus_if.wr_data = {32'h0, 32'hCAFEF00D};
      bus_if.rs_addr = {5'd0, 5'd7};
      #1;
      check("bypass_hit", bus_if.rs_data[31:0], 32'hCAFEF00D);
      bus_if.stall = 1'b1;
      #1;
      check("bypass_stall", bus_if.rs_data[31:0], 32'h00000001);
      tick();
      idle();
      #1;
      check("stall_no_write", bus_if.rs_data[31:0], 32'h00000001);

      // scoreboard: issue sets busy one cycle later
      bus_if.issue_en = 1'b1;
      bus_if.issue_rd = 5'd9;
      bus_if.rs_addr  = {5'd9, 5'd0};
      #1;
      check("issue_not_yet", 32'(bus_if.rs_busy[1]), 32'h0);
      tick();
      idle();
      #1;
      check("issue_busy", 32'(bus_if.rs_busy[1]), 32'h1);
      // a same-cycle write to reg9 is bypassed, so busy is masked
      bus_if.wr_en    = 2'b01;
      bus_if.wr_addr  = {5'd0, 5'd9};
      bus_if.wr_data  = {32'h0, 32'h00000099};
      bus_if.issue_en = 1'b1;
      bus_if.issue_rd = 5'd9;
      #1;
      check("busy_mask_bypass", 32'(bus_if.rs_busy[1]), 32'h0);
      tick();
      idle();
      #1;
      check("set_beats_clear", 32'(bus_if.rs_busy[1]), 32'h1);
      check("set_clear_data", bus_if.rs_data[63:32], 32'h00000099);
      bus_if.wr_en   = 2'b10;
      bus_if.wr_addr = {5'd9, 5'd0};
      bus_if.wr_data = {32'h00000777, 32'h0};
      tick();
      idle();
      #1;
      check("write_clears_busy", 32'(bus_if.rs_busy[1]), 32'h0);
      check("write_clears_data", bus_if.rs_data[63:32], 32'h00000777);

      // issue under stall is ignored
      bus_if.stall    = 1'b1;
      bus_if.issue_en = 1'b1;
      bus_if.issue_rd = 5'd10;
      bus_if.rs_addr  = {5'd10, 5'd10};
      tick();
      idle();
      #1;
      check("stall_issue", 32'(bus_if.rs_busy), 32'h0);

      // register 0 hardwired
      bus_if.wr_en    = 2'b01;
      bus_if.wr_addr  = {5'd0, 5'd0};
      bus_if.wr_data  = {32'h0, 32'hFFFFFFFF};
      bus_if.issue_en = 1'b1;
      bus_if.issue_rd = 5'd0;
      bus_if.rs_addr  = {5'd0, 5'd0};
      #1;
      check("r0_comb_data", bus_if.rs_data[31:0], 32'h0);
      check("r0_comb_busy", 32'(bus_if.rs_busy), 32'h0);
      tick();
      idle();
      #1;
      check("r0_data_p0", bus_if.rs_data[31:0], 32'h0);
      check("r0_data_p1", bus_if.rs_data[63:32], 32'h0);
      check("r0_busy", 32'(bus_if.rs_busy), 32'h0);

      // reset wins over stall and a pending write
      bus_if.wr_en    = 2'b01;
      bus_if.wr_addr  = {5'd0, 5'd3};
      bus_if.wr_data  = {32'h0, 32'hA5A5A5A5};
      bus_if.issue_en = 1'b1;
      bus_if.issue_rd = 5'd3;
      tick();
      idle();
      bus_if.rs_addr = {5'd3, 5'd3};
      #1;
      check("r3_loaded", bus_if.rs_data[31:0], 32'hA5A5A5A5);
      check("r3_busy", 32'(bus_if.rs_busy), 32'h3);
      reset          = 1'b1;
      bus_if.stall   = 1'b1;
      bus_if.wr_en   = 2'b01;
      bus_if.wr_addr = {5'd0, 5'd3};
      bus_if.wr_data = {32'h0, 32'h55555555};
      tick();
      reset = 1'b0;
      idle();
      #1;
      check("rst_mid_data", bus_if.rs_data[31:0], 32'h0);
      check("rst_mid_busy", 32'(bus_if.rs_busy), 32'h0);
      bus_if.rs_addr = {5'd5, 5'd9};
      #1;
      check("rst_mid_r9", bus_if.rs_data[31:0], 32'h0);
      check("rst_mid_r5", bus_if.rs_data[63:32], 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
